// File: rtl/vampire_colorize_pkg.sv
// Shared types and constants for the Vampire4 colorize stage.
package vampire_colorize_pkg;

   typedef enum logic [1:0] {
      BLACK    = 2'd0,
      FADE_IN  = 2'd1,
      ON       = 2'd2,
      FADE_OUT = 2'd3
   } fade_state_t;

   localparam logic [7:0] FADE_MAX = 8'd255;

endpackage

// File: rtl/vampire_scale8.sv
// Unsigned 8-bit sample times 9-bit factor, keeping the upper byte (y = (a*k) >> 8).
module vampire_scale8 (
   input  logic [7:0] a,
   input  logic [8:0] k,
   output logic [7:0] y
);

   // 255 * 256 = 65280 still fits in 16 bits, so no carry bit is lost.
   logic [15:0] prod;

   assign prod = {8'd0, a} * {7'd0, k};
   assign y    = prod[15:8];

endmodule

// File: rtl/vampire_colorize.sv
// Tints the intensity stream into RGB, applies a frame-synchronous fade and forces black in blanking.
import vampire_colorize_pkg::*;

module vampire_colorize #(
   parameter logic [7:0] TINT_R    = 8'd64,
   parameter logic [7:0] TINT_G    = 8'd255,
   parameter logic [7:0] TINT_B    = 8'd96,
   parameter logic [7:0] FADE_STEP = 8'd8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       ce_pix,
   input  logic       HBlank_in,
   input  logic       HSync_in,
   input  logic       VBlank_in,
   input  logic       VSync_in,
   input  logic [7:0] video_in,
   output logic       ce_pix_out,
   output logic       HBlank,
   output logic       HSync,
   output logic       VBlank,
   output logic       VSync,
   output logic [7:0] r,
   output logic [7:0] g,
   output logic [7:0] b,
   output logic [7:0] fade_level,
   output logic       fade_busy
);

   localparam logic [23:0] TINTS = {TINT_B, TINT_G, TINT_R};

   logic [7:0]  v1_reg;
   logic        hb1_reg, hs1_reg, vb1_reg, vs1_reg;
   logic [7:0]  c2_reg [3];
   logic [7:0]  c2_next [3];
   logic        hb2_reg, hs2_reg, vb2_reg, vs2_reg;
   logic [7:0]  rgb_reg [3];
   logic [7:0]  rgb_next [3];
   logic        hb3_reg, hs3_reg, vb3_reg, vs3_reg;
   logic        ce_pix_out_reg;

   fade_state_t state_reg;
   logic [7:0]  fade_level_reg;
   logic        fade_busy_reg;
   logic        vs_prev_reg;
   logic        tick;
   logic [8:0]  fade_k;
   logic [8:0]  level_up;
   logic [8:0]  level_dn;
   logic [7:0]  level_up_sat;
   logic [7:0]  level_dn_sat;

   // fade_level 255 maps to factor 256 so a fully-on channel passes unchanged.
   assign fade_k = {1'b0, fade_level_reg} + 9'd1;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_chan
         vampire_scale8 u_tint (
            .a (v1_reg),
            .k ({1'b0, TINTS[gi*8 +: 8]}),
            .y (c2_next[gi])
         );
         vampire_scale8 u_fade (
            .a (c2_reg[gi]),
            .k (fade_k),
            .y (rgb_next[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_reg  <= 8'd0;
         hb1_reg <= 1'b0;
         hs1_reg <= 1'b0;
         vb1_reg <= 1'b0;
         vs1_reg <= 1'b0;
         hb2_reg <= 1'b0;
         hs2_reg <= 1'b0;
         vb2_reg <= 1'b0;
         vs2_reg <= 1'b0;
         hb3_reg <= 1'b0;
         hs3_reg <= 1'b0;
         vb3_reg <= 1'b0;
         vs3_reg <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            c2_reg[i]  <= 8'd0;
            rgb_reg[i] <= 8'd0;
         end
      end else if (ce_pix) begin
         v1_reg  <= video_in;
         hb1_reg <= HBlank_in;
         hs1_reg <= HSync_in;
         vb1_reg <= VBlank_in;
         vs1_reg <= VSync_in;
         hb2_reg <= hb1_reg;
         hs2_reg <= hs1_reg;
         vb2_reg <= vb1_reg;
         vs2_reg <= vs1_reg;
         hb3_reg <= hb2_reg;
         hs3_reg <= hs2_reg;
         vb3_reg <= vb2_reg;
         vs3_reg <= vs2_reg;
         for (int i = 0; i < 3; i++) begin
            c2_reg[i]  <= c2_next[i];
            rgb_reg[i] <= (hb2_reg || vb2_reg) ? 8'd0 : rgb_next[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ce_pix_out_reg <= 1'b0;
      else       ce_pix_out_reg <= ce_pix;
   end

   // Frame tick: VSync rising edge, seen only through pixel-enabled samples.
   assign tick = ce_pix && VSync_in && !vs_prev_reg;

   assign level_up     = {1'b0, fade_level_reg} + {1'b0, FADE_STEP};
   assign level_dn     = {1'b0, fade_level_reg} - {1'b0, FADE_STEP};
   assign level_up_sat = level_up[8] ? FADE_MAX : level_up[7:0];
   assign level_dn_sat = level_dn[8] ? 8'd0 : level_dn[7:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= BLACK;
         fade_level_reg <= 8'd0;
         fade_busy_reg  <= 1'b0;
         vs_prev_reg    <= 1'b0;
      end else begin
         if (ce_pix) vs_prev_reg <= VSync_in;
         if (tick) begin
            case (state_reg)
               BLACK: begin
                  if (enable) begin
                     state_reg     <= FADE_IN;
                     fade_busy_reg <= 1'b1;
                  end
               end
               FADE_IN: begin
                  if (!enable) begin
                     state_reg <= FADE_OUT;
                  end else begin
                     fade_level_reg <= level_up_sat;
                     if (level_up_sat == FADE_MAX) begin
                        state_reg     <= ON;
                        fade_busy_reg <= 1'b0;
                     end
                  end
               end
               ON: begin
                  if (!enable) begin
                     state_reg     <= FADE_OUT;
                     fade_busy_reg <= 1'b1;
                  end
               end
               FADE_OUT: begin
                  if (enable) begin
                     state_reg <= FADE_IN;
                  end else begin
                     fade_level_reg <= level_dn_sat;
                     if (level_dn_sat == 8'd0) begin
                        state_reg     <= BLACK;
                        fade_busy_reg <= 1'b0;
                     end
                  end
               end
               default: state_reg <= BLACK;
            endcase
         end
      end
   end

   assign ce_pix_out = ce_pix_out_reg;
   assign HBlank     = hb3_reg;
   assign HSync      = hs3_reg;
   assign VBlank     = vb3_reg;
   assign VSync      = vs3_reg;
   assign r          = rgb_reg[0];
   assign g          = rgb_reg[1];
   assign b          = rgb_reg[2];
   assign fade_level = fade_level_reg;
   assign fade_busy  = fade_busy_reg;

endmodule

// File: tb/tb_vampire_colorize.sv
// Directed vectors for vampire_colorize: latency, blanking, fade sequencing, stall and reset.
module tb_vampire_colorize;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       ce_pix;
   logic       HBlank_in, HSync_in, VBlank_in, VSync_in;
   logic [7:0] video_in;
   logic       ce_pix_out;
   logic       HBlank, HSync, VBlank, VSync;
   logic [7:0] r, g, b;
   logic [7:0] fade_level;
   logic       fade_busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vampire_colorize dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .ce_pix     (ce_pix),
      .HBlank_in  (HBlank_in),
      .HSync_in   (HSync_in),
      .VBlank_in  (VBlank_in),
      .VSync_in   (VSync_in),
      .video_in   (video_in),
      .ce_pix_out (ce_pix_out),
      .HBlank     (HBlank),
      .HSync      (HSync),
      .VBlank     (VBlank),
      .VSync      (VSync),
      .r          (r),
      .g          (g),
      .b          (b),
      .fade_level (fade_level),
      .fade_busy  (fade_busy)
   );

   typedef struct {
      logic [7:0] v;
      logic       hb, hs, vb, vs;
      logic [7:0] er, eg, eb;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // One clk with the given pixel enable; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic ce);
      ce_pix = ce;
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      VSync_in = 1'b0;
      step(1'b1);
      VSync_in = 1'b1;
      step(1'b1);
   endtask

   task automatic pixel(input logic [7:0] v, input logic hb, input logic hs,
                        input logic vb, input logic vs);
      video_in  = v;
      HBlank_in = hb;
      HSync_in  = hs;
      VBlank_in = vb;
      VSync_in  = vs;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0);
      reset = 1'b0;
   endtask

   initial begin
      //          v    hb    hs    vb    vs    r    g    b
      tbl[0] = '{8'd200, 1'b0, 1'b0, 1'b0, 1'b0, 8'd50, 8'd199, 8'd75};
      tbl[1] = '{8'd255, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,   8'd0};
      tbl[2] = '{8'd100, 1'b0, 1'b1, 1'b0, 1'b0, 8'd25, 8'd99,  8'd37};
      tbl[3] = '{8'd255, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,  8'd0,   8'd0};
      tbl[4] = '{8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 8'd63, 8'd254, 8'd95};
      tbl[5] = '{8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,   8'd0};
      tbl[6] = '{8'd128, 1'b0, 1'b1, 1'b0, 1'b1, 8'd32, 8'd127, 8'd48};
      tbl[7] = '{8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,   8'd0};
      tbl[8] = '{8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,   8'd0};
      tbl[9] = '{8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,   8'd0};

      enable = 1'b0;
      ce_pix = 1'b0;
      pixel(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      step(1'b1);
      step(1'b1);
      reset = 1'b0;

      // Reset state
      chk("reset_r", r, 0);
      chk("reset_g", g, 0);
      chk("reset_b", b, 0);
      chk("reset_hsync", HSync, 0);
      chk("reset_ce_out", ce_pix_out, 0);
      chk("reset_level", fade_level, 0);
      chk("reset_busy", fade_busy, 0);

      // Fade in to level 128, check the fade math, then reset mid-fade
      enable = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         do_tick();
         if (k == 1) begin
            chk("fi1_level", fade_level, 0);
            chk("fi1_busy", fade_busy, 1);
         end
         if (k == 2) chk("fi2_level", fade_level, 8);
      end
      chk("fi17_level", fade_level, 128);
      pixel(8'd255, 1'b1, 1'b1, 1'b1, 1'b1);
      HBlank_in = 1'b0;
      VBlank_in = 1'b0;
      step(1'b1);
      step(1'b1);
      step(1'b1);
      chk("fade128_r", r, 31);
      chk("fade128_g", g, 127);
      chk("fade128_b", b, 47);
      chk("fade128_hsync", HSync, 1);
      do_reset();
      chk("midrst_r", r, 0);
      chk("midrst_g", g, 0);
      chk("midrst_b", b, 0);
      chk("midrst_hsync", HSync, 0);
      chk("midrst_level", fade_level, 0);
      chk("midrst_busy", fade_busy, 0);

      // Full fade in from scratch
      pixel(8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 33; k++) begin
         do_tick();
         if (k == 32) begin
            chk("fi32_level", fade_level, 248);
            chk("fi32_busy", fade_busy, 1);
         end
      end
      chk("fi33_level", fade_level, 255);
      chk("fi33_busy", fade_busy, 0);

      // Latency and blanking vectors with ce_pix toggling every clk
      for (int j = 0; j < 10; j++) begin
         pixel(tbl[j].v, tbl[j].hb, tbl[j].hs, tbl[j].vb, tbl[j].vs);
         step(1'b1);
         if (j >= 2) begin
            chk($sformatf("vec%0d_r", j - 2), r, tbl[j-2].er);
            chk($sformatf("vec%0d_g", j - 2), g, tbl[j-2].eg);
            chk($sformatf("vec%0d_b", j - 2), b, tbl[j-2].eb);
            chk($sformatf("vec%0d_blank_sync", j - 2),
                {HBlank, HSync, VBlank, VSync},
                {tbl[j-2].hb, tbl[j-2].hs, tbl[j-2].vb, tbl[j-2].vs});
         end
         if (j == 1) chk("vec_ce_out_hi", ce_pix_out, 1);
         step(1'b0);
         if (j == 1) chk("vec_ce_out_lo", ce_pix_out, 0);
      end

      // Stall: outputs hold, a VSync rise during ce_pix=0 is not a tick
      pixel(8'd255, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1);
      step(1'b1);
      step(1'b1);
      enable = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c == 3) pixel(8'd7, 1'b0, 1'b0, 1'b0, 1'b1);
         step(1'b0);
         if (c == 0 || c == 5 || c == 9) begin
            chk($sformatf("stall%0d_g", c), g, 254);
            chk($sformatf("stall%0d_hsync", c), HSync, 1);
            chk($sformatf("stall%0d_busy", c), fade_busy, 0);
         end
      end
      step(1'b1);
      chk("post_stall_busy", fade_busy, 1);
      chk("post_stall_level", fade_level, 255);

      // Fade out, then reverse
      do_tick();
      chk("fo2_level", fade_level, 247);
      do_tick();
      chk("fo3_level", fade_level, 239);
      enable = 1'b1;
      do_tick();
      chk("rev_level", fade_level, 239);
      chk("rev_busy", fade_busy, 1);
      do_tick();
      chk("rev2_level", fade_level, 247);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vampire_colorize.md
Name: vampire_colorize

Overview:
Downstream stage of the Vampire4 pattern generator. It takes the 8-bit intensity stream with its blank/sync strobes, applies a per-channel RGB tint and a frame-synchronous fade level, and forces black during blanking. The result is 24-bit RGB with blank/sync delayed to match. It sits between the pattern generator and the framework video output.

Parameters:
TINT_R, 8'd64, red tint multiplier, 0..255.
TINT_G, 8'd255, green tint multiplier.
TINT_B, 8'd96, blue tint multiplier.
FADE_STEP, 8'd8, fade level change per frame; must be nonzero.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  1 = fade in and stay on; 0 = fade out and stay black.
ce_pix  in  1  pixel enable from the generator.
HBlank_in  in  1  horizontal blank.
HSync_in  in  1  horizontal sync.
VBlank_in  in  1  vertical blank.
VSync_in  in  1  vertical sync, active high.
video_in  in  8  intensity.
ce_pix_out  out  1  ce_pix delayed by 1 clk.
HBlank  out  1  delayed blank.
HSync  out  1  delayed sync.
VBlank  out  1  delayed blank.
VSync  out  1  delayed sync.
r  out  8  red.
g  out  8  green.
b  out  8  blue.
fade_level  out  8  current fade level.
fade_busy  out  1  high in FADE_IN or FADE_OUT.

Behaviour:
- Clock and reset: one clock (clk); synchronous, active-high reset (reset).
- Reset values:
  - All outputs and pipeline registers 0.
  - FSM in BLACK, fade_level 0, vsync edge register 0.
- Pipeline:
  - 3 stages; each advances only in cycles with ce_pix=1; stalled otherwise.
  - Latency is 3 ce_pix cycles for data and for all four blank/sync bits. They travel together and have identical delay.
- S1: register video_in, HBlank_in, HSync_in, VBlank_in and VSync_in.
- S2: tint per channel.
  - c = (v * TINT_x) >> 8, using an 8x8 multiply with a 16-bit product; the upper byte is kept.
- S3: fade per channel.
  - out = (c * (fade_level + 1)) >> 8, using a 9-bit factor.
  - fade_level 255 gives out = c. fade_level 0 gives out = 0.
  - If the S2 HBlank or VBlank is 1, r/g/b = 0 regardless of fade.
- ce_pix_out: registered copy of ce_pix every clk, independent of reset except that it is cleared by reset.
- Frame tick:
  - Rising edge of VSync_in, sampled only in ce_pix cycles (previous-value register updated on ce_pix).
  - fade_level changes only on a tick, so it is constant within a frame.
- FSM states: BLACK, FADE_IN, ON, FADE_OUT. Transitions are evaluated on a tick only.
  - BLACK: enable=1 -> FADE_IN. Level unchanged (0).
  - FADE_IN:
    - enable=0 -> FADE_OUT, level unchanged on this tick.
    - Otherwise level = min(level + FADE_STEP, 255).
    - If the new level is 255 -> ON.
  - ON: enable=0 -> FADE_OUT.
  - FADE_OUT:
    - enable=1 -> FADE_IN, level unchanged.
    - Otherwise level = max(level - FADE_STEP, 0) (saturating subtraction, 9-bit intermediate).
    - If the new level is 0 -> BLACK.
- fade_busy = (state == FADE_IN) or (state == FADE_OUT).
- Simultaneous tick and reset: reset wins.
- Reset mid-frame: outputs black immediately on the next clk. The pipeline refills after 3 ce_pix cycles with fade_level 0.
- enable toggling between ticks has no effect until the next tick. Only the value at the tick counts.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit typedef: BLACK=0, FADE_IN=1, ON=2, FADE_OUT=3).
  - Constant FADE_MAX = 8'd255.
- One natural sub-module: vampire_scale8. It is an 8x9 multiply with >>8, instantiated six times (3 tint and 3 fade), or purely combinational inside the stage registers.

Test Plan:
- Latency: reset, hold enable=1 until ON, video_in=200 at one ce_pix cycle with ce_pix toggling every clk.
  - Required: g = (200*255)>>8 = 199 exactly 3 ce_pix cycles later.
  - Required: r = 50, b = 75.
  - Required: blank/sync transitions also appear 3 ce_pix cycles after input.
- Blank forcing: video_in=255 with HBlank_in=1 -> r=g=b=0 3 ce_pix cycles later; HBlank=1 on the same cycle.
- Fade-in: enable=1 from reset, FADE_STEP=8.
  - Required: after tick 1 state is FADE_IN with level 0; after tick 2 level 8.
  - Required: level reaches 248 after tick 32 and 255 (saturated) after tick 33, with state ON and fade_busy=0.
- Fade-out with reversal: in ON, enable=0.
  - Required: ticks give levels 255, 247, 239.
  - Then enable=1: the next tick gives FADE_IN with level unchanged at 239, then 247.
- Stall: ce_pix=0 for 10 clks mid-line -> r/g/b and sync outputs hold their values; no tick is detected even if VSync_in rises during the stall; it is detected on the first ce_pix cycle after.
- Reset mid-fade: at level 128 in FADE_IN, assert reset for 1 clk -> next clk all outputs 0, state BLACK, fade_level 0.
